// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, resolves B/BR at fetch time,
// stalls on Bcond until decode resolves it, and buffers fetched words in a
// DEPTH-entry circular queue drained by decode through a valid/ready handshake.
module if_prefetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP_WORD = 32'hC8000000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [ADDR_W-1:0]          im_addr,
    input  logic [31:0]                im_data,
    output logic [2:0]                 br_addr,
    input  logic [31:0]                br_value,
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic [ADDR_W-1:0]          res_pc,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          flush_pc,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [31:0]                id_instr,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    localparam logic [6:0] OpB     = 7'b1100000;
    localparam logic [6:0] OpBcond = 7'b1100001;
    localparam logic [6:0] OpBr    = 7'b1100010;

    typedef enum logic {StFetch, StWaitCond} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [31:0]       instr_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem    [DEPTH];

    logic              fire;
    logic              pop;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] b_target;
    logic [ADDR_W-1:0] br_target;

    // Low target bits are always forced to zero, so these inputs carry no information.
    logic unused_low_bits;
    assign unused_low_bits = ^{res_pc[1:0], flush_pc[1:0]};

    assign offset    = ADDR_W'($signed(im_data[15:0]));
    assign b_target  = fpc_q + offset;
    assign br_target = br_value[ADDR_W-1:0] + offset;

    assign im_addr  = fpc_q;
    assign br_addr  = im_data[24:22];
    assign id_valid = (count_q != '0);
    assign id_instr = id_valid ? instr_mem[rd_ptr_q] : NOP_WORD;
    assign id_pc    = id_valid ? pc_mem[rd_ptr_q] : '0;
    assign q_count  = count_q;

    // Flush kills a concurrent pop so the head is not consumed twice in effect.
    assign pop = id_valid & id_ready & ~flush;

    // Next fetch PC / state: flush > resolve > fetch.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        fire    = 1'b0;
        if (flush) begin
            state_d = StFetch;
            fpc_d   = {flush_pc[ADDR_W-1:2], 2'b00};
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (count_q != Full) begin
                        fire = 1'b1;
                        case (im_data[31:25])
                            OpB:     fpc_d = {b_target[ADDR_W-1:2], 2'b00};
                            OpBr:    fpc_d = {br_target[ADDR_W-1:2], 2'b00};
                            OpBcond: state_d = StWaitCond;
                            default: fpc_d = fpc_q + ADDR_W'(4);
                        endcase
                    end
                end
                StWaitCond: begin
                    if (res_valid) begin
                        state_d = StFetch;
                        fpc_d   = res_taken ? {res_pc[ADDR_W-1:2], 2'b00}
                                            : fpc_q + ADDR_W'(4);
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    // Fetch PC and FSM state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            fpc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
        end
    end

    // Queue pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fire) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({fire, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage; contents are only meaningful below count_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (fire) begin
            instr_mem[wr_ptr_q] <= im_data;
            pc_mem[wr_ptr_q]    <= fpc_q;
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: a cycle model predicts the fetch PC, and every
// fetched {pc, word} is pushed to a scoreboard queue and compared against the
// DUT queue head, alongside directed checks of the key addresses.
module tb_if_prefetch_queue;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] NOP    = 32'hC8000000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        reset;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic [2:0]  br_addr;
    logic [31:0] br_value;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [2:0]  q_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_fpc;
    logic        m_wait;
    ent_t        m_q[$];

    if_prefetch_queue #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0),
        .NOP_WORD (NOP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .im_addr   (im_addr),
        .im_data   (im_data),
        .br_addr   (br_addr),
        .br_value  (br_value),
        .res_valid (res_valid),
        .res_taken (res_taken),
        .res_pc    (res_pc),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_instr  (id_instr),
        .id_pc     (id_pc),
        .q_count   (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: a few branches, every other address holds a non-branch word.
    function automatic logic [31:0] prog_word(input logic [31:0] a);
        case (a)
            32'h20:  return {7'b1100000, 9'd0, 16'hFFF8};
            32'h40:  return {7'b1100010, 3'd3, 6'd0, 16'h0010};
            32'h50:  return {7'b1100001, 9'd0, 16'h0000};
            32'h60:  return {7'b1100000, 9'd0, 16'h0006};
            default: return {7'h00, a[24:0]};
        endcase
    endfunction

    function automatic logic [31:0] reg_val(input logic [2:0] idx);
        return (idx == 3'd3) ? 32'h1000 : 32'h0;
    endfunction

    assign im_data  = prog_word(im_addr);
    assign br_value = reg_val(br_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: compare DUT against the model at negedge, advance the model, return at posedge+1.
    task automatic step();
        logic [31:0] w;
        logic [31:0] off;
        logic        do_pop;
        logic        do_fire;
        ent_t        e;
        @(negedge clk);
        check("im_addr", im_addr, m_fpc);
        check("q_count", 32'(q_count), 32'(m_q.size()));
        check("id_valid", 32'(id_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("sb_pc", id_pc, m_q[0].pc);
            check("sb_instr", id_instr, m_q[0].instr);
        end else begin
            check("empty_pc", id_pc, 32'h0);
            check("empty_instr", id_instr, NOP);
        end
        if (reset) begin
            m_fpc  = 32'h0;
            m_wait = 1'b0;
            m_q.delete();
        end else if (flush) begin
            m_fpc  = flush_pc & ~32'h3;
            m_wait = 1'b0;
            m_q.delete();
        end else begin
            do_pop  = (m_q.size() != 0) && id_ready;
            do_fire = !m_wait && (m_q.size() < DEPTH);
            w       = prog_word(m_fpc);
            off     = {{16{w[15]}}, w[15:0]};
            if (do_pop) void'(m_q.pop_front());
            if (do_fire) begin
                e.pc    = m_fpc;
                e.instr = w;
                m_q.push_back(e);
            end
            if (m_wait) begin
                if (res_valid) begin
                    m_fpc  = res_taken ? (res_pc & ~32'h3) : m_fpc + 32'd4;
                    m_wait = 1'b0;
                end
            end else if (do_fire) begin
                case (w[31:25])
                    7'b1100000: m_fpc = (m_fpc + off) & ~32'h3;
                    7'b1100010: m_fpc = (reg_val(w[24:22]) + off) & ~32'h3;
                    7'b1100001: m_wait = 1'b1;
                    default:    m_fpc = m_fpc + 32'd4;
                endcase
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        step();
        flush    = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        res_valid = 1'b0;
        res_taken = 1'b0;
        res_pc    = 32'h0;
        flush     = 1'b0;
        flush_pc  = 32'h0;
        id_ready  = 1'b0;
        m_fpc     = 32'h0;
        m_wait    = 1'b0;
        @(posedge clk);
        #1;
        check("rst_addr", im_addr, 32'h0);
        check("rst_count", 32'(q_count), 32'h0);
        check("rst_valid", 32'(id_valid), 32'h0);
        check("rst_instr", id_instr, NOP);
        check("rst_pc", id_pc, 32'h0);
        step();

        // Straight-line fetch, decode always ready.
        reset    = 1'b0;
        id_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("line_addr", im_addr, 32'(4 * k));
            check("line_idpc", id_pc, 32'(4 * (k - 1)));
            check("line_count", 32'(q_count), 32'h1);
        end

        // Backpressure: fill, hold, then drain in order.
        reset = 1'b1;
        step();
        reset    = 1'b0;
        id_ready = 1'b0;
        repeat (6) step();
        check("bp_addr", im_addr, 32'h10);
        check("bp_count", 32'(q_count), 32'h4);
        id_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_order", id_pc, 32'(4 * i));
            step();
        end

        // B backward and B with a misaligned offset.
        do_flush(32'h20);
        check("flush_valid", 32'(id_valid), 32'h0);
        check("b_at", im_addr, 32'h20);
        step();
        check("b_back", im_addr, 32'h18);
        check("b_enq", id_instr, prog_word(32'h20));
        do_flush(32'h60);
        step();
        check("b_align", im_addr, 32'h64);

        // BR through the register file.
        do_flush(32'h40);
        check("br_addr", 32'(br_addr), 32'h3);
        step();
        check("br_tgt", im_addr, 32'h1010);

        // res_valid while fetching is ignored.
        res_valid = 1'b1;
        res_taken = 1'b1;
        res_pc    = 32'h700;
        step();
        res_valid = 1'b0;
        check("res_ign", im_addr, 32'h1014);

        // Bcond not taken, then taken with a misaligned target.
        for (int t = 0; t < 2; t++) begin
            do_flush(32'h50);
            step();
            repeat (2) step();
            check("bc_stall", im_addr, 32'h50);
            check("bc_drain", 32'(q_count), 32'h0);
            res_valid = 1'b1;
            res_taken = (t == 1);
            res_pc    = 32'h203;
            step();
            res_valid = 1'b0;
            check("bc_res", im_addr, (t == 1) ? 32'h200 : 32'h54);
            step();
            check("bc_head", id_pc, (t == 1) ? 32'h200 : 32'h54);
        end

        // Flush while full with a concurrent pop.
        id_ready = 1'b0;
        do_flush(32'h80);
        repeat (5) step();
        check("fl_full", 32'(q_count), 32'h4);
        id_ready = 1'b1;
        do_flush(32'h300);
        check("fl_count", 32'(q_count), 32'h0);
        check("fl_valid", 32'(id_valid), 32'h0);
        check("fl_addr", im_addr, 32'h300);
        step();
        check("fl_head", id_pc, 32'h300);

        // Reset while waiting on a Bcond.
        do_flush(32'h50);
        repeat (2) step();
        check("wr_stall", im_addr, 32'h50);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("wr_addr", im_addr, 32'h0);
        check("wr_count", 32'(q_count), 32'h0);
        check("wr_valid", 32'(id_valid), 32'h0);
        step();
        check("wr_fetch", im_addr, 32'h4);
        check("wr_count1", 32'(q_count), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
